selector_dw_pipe: RTL and testbench

Parametrised, registered successor of the write-back data selector in the microcontroller datapath. It picks one of `N_SRC` source words (register R0, memory data, immediate, instruction address, Ry, …) by selector code and delivers it as the write-back word DW through a one-cycle pipeline stage with a valid/ready handshake and a two-entry skid buffer. The block sits between operand/result sources and the register-file write port, so a write-port stall never drops or duplicates a write-back beat.

---
 rtl/selector_dw_pipe_pkg.sv | 22 ++
 rtl/selector_dw_pipe_if.sv | 30 +++
 rtl/selector_dw_pipe_skid.sv | 73 +++++++
 rtl/selector_dw_pipe.sv | 72 +++++++
 tb/tb_selector_dw_pipe.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/selector_dw_pipe_pkg.sv
// Shared constants and types for the write-back selector pipeline.
package micro_pkg;

  localparam int SEL_R0    = 0;
  localparam int SEL_DATO  = 1;
  localparam int SEL_NUM   = 2;
  localparam int SEL_DIR   = 3;
  localparam int SEL_RY    = 4;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/selector_dw_pipe_if.sv
// Handshake and data bus between the operand sources and the write-back stage.
interface selector_dw_pipe_if
  import micro_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_SRC = 5
);
  localparam int SEL_W = $clog2(N_SRC);

  logic [SEL_W-1:0]       i_sel;
  logic [N_SRC*WIDTH-1:0] i_src;
  logic                   i_valid;
  logic                   o_ready;
  logic [WIDTH-1:0]       o_dw;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_sel_err;
  logic [ERR_CNT_W-1:0]   o_err_cnt;

  modport master (
    output i_sel, i_src, i_valid, i_ready,
    input  o_ready, o_dw, o_valid, o_sel_err, o_err_cnt
  );

  modport slave (
    input  i_sel, i_src, i_valid, i_ready,
    output o_ready, o_dw, o_valid, o_sel_err, o_err_cnt
  );

endinterface

// File: rtl/selector_dw_pipe_skid.sv
// Generic two-entry valid/ready buffer; main entry drives the output, skid absorbs one stall.
module skid_buffer_2
  import micro_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i
);

  state_e        state_q;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          valid_q;
  logic          ready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (valid_i) begin
            main_q  <= data_i;
            state_q <= ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        ONE: begin
          if (valid_i && ready_i) begin
            main_q <= data_i;
          end else if (valid_i) begin
            skid_q  <= data_i;
            state_q <= TWO;
            ready_q <= 1'b0;
          end else if (ready_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        TWO: begin
          // Upstream is stalled here, so only the drain side can move.
          if (ready_i) begin
            main_q  <= skid_q;
            state_q <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign data_o  = main_q;
  assign valid_o = valid_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/selector_dw_pipe.sv
// Write-back word selector: source mux, skid-buffered output stage, saturating error counter.
module selector_dw_pipe
  import micro_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_SRC = 5
) (
  input logic                i_clk,
  input logic                i_rst_n,
  selector_dw_pipe_if.slave  bus
);

  localparam int SEL_W = $clog2(N_SRC);

  logic [N_SRC-1:0]     hit;
  logic [WIDTH-1:0]     masked [N_SRC];
  logic [WIDTH-1:0]     sel_word;
  logic                 sel_err;
  logic                 ready;
  logic                 accept;
  logic [WIDTH:0]       out_data;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign hit[gi]    = (bus.i_sel == SEL_W'(gi));
      assign masked[gi] = hit[gi] ? bus.i_src[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  // An out-of-range code matches no source, yielding a zero word flagged as error.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sel_word = sel_word | masked[k];
    end
  end

  assign sel_err = ~|hit;
  assign accept  = bus.i_valid && ready;

  skid_buffer_2 #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .data_i  ({sel_err, sel_word}),
    .valid_i (bus.i_valid),
    .ready_o (ready),
    .data_o  (out_data),
    .valid_o (bus.o_valid),
    .ready_i (bus.i_ready)
  );

  assign err_cnt_d = (accept && sel_err) ? sat_inc(err_cnt_q) : err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_dw      = out_data[WIDTH-1:0];
  assign bus.o_sel_err = out_data[WIDTH];
  assign bus.o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_selector_dw_pipe.sv
// Self-checking bench for selector_dw_pipe: directed scenarios plus a random queue-model run.
module tb_selector_dw_pipe;

  localparam int WIDTH = 8;
  localparam int N_SRC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [N_SRC*WIDTH-1:0] src_fixed;

  selector_dw_pipe_if #(.WIDTH(WIDTH), .N_SRC(N_SRC)) bus ();

  selector_dw_pipe #(.WIDTH(WIDTH), .N_SRC(N_SRC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected {err, word} for a beat, straight from the selection rule.
  function automatic logic [WIDTH:0] ref_beat(input logic [2:0] s, input logic [N_SRC*WIDTH-1:0] src);
    logic [WIDTH:0] b;
    if (int'(s) < N_SRC) b = {1'b0, src[int'(s)*WIDTH +: WIDTH]};
    else                 b = {1'b1, {WIDTH{1'b0}}};
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b0;
    bus.i_sel = 3'd3;
    cycle();
    cycle();
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.o_ready); end
    checks++; if (bus.o_dw !== 8'd0) begin errors++; $display("FAIL reset_dw got %0d want 0", bus.o_dw); end
    checks++; if (bus.o_sel_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", bus.o_sel_err); end
    checks++; if (bus.o_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.o_err_cnt); end
    cycle();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got %0b want 0", bus.o_valid); end
    $display("test_reset done");
  endtask

  task automatic test_in_range();
    bus.i_src = src_fixed;
    bus.i_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      bus.i_sel = 3'(s);
      bus.i_valid = 1'b1;
      cycle();
      $display("in_range sel=%0d dw=%0d valid=%0b", s, bus.o_dw, bus.o_valid);
      checks++; if (bus.o_dw !== 8'(s)) begin errors++; $display("FAIL in_range_dw got %0d want %0d", bus.o_dw, s); end
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL in_range_valid got %0b want 1", bus.o_valid); end
      checks++; if (bus.o_sel_err !== 1'b0) begin errors++; $display("FAIL in_range_err got %0b want 0", bus.o_sel_err); end
    end
    bus.i_valid = 1'b0;
    cycle();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL in_range_drain got %0b want 0", bus.o_valid); end
  endtask

  task automatic test_out_of_range();
    bus.i_ready = 1'b1;
    for (int s = 5; s < 8; s++) begin
      bus.i_sel = 3'(s);
      bus.i_valid = 1'b1;
      cycle();
      $display("out_of_range sel=%0d dw=%0d err=%0b", s, bus.o_dw, bus.o_sel_err);
      checks++; if (bus.o_dw !== 8'd0) begin errors++; $display("FAIL oor_dw got %0d want 0", bus.o_dw); end
      checks++; if (bus.o_sel_err !== 1'b1) begin errors++; $display("FAIL oor_err got %0b want 1", bus.o_sel_err); end
    end
    bus.i_valid = 1'b0;
    cycle();
    checks++; if (bus.o_err_cnt !== 8'd3) begin errors++; $display("FAIL oor_cnt got %0d want 3", bus.o_err_cnt); end
  endtask

  task automatic test_full();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_sel = 3'd2;
    cycle();
    checks++; if (bus.o_dw !== 8'd2 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL full_first got dw=%0d v=%0b want dw=2 v=1", bus.o_dw, bus.o_valid); end
    bus.i_sel = 3'd4;
    cycle();
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", bus.o_ready); end
    checks++; if (bus.o_dw !== 8'd2) begin errors++; $display("FAIL full_hold got %0d want 2", bus.o_dw); end
    bus.i_sel = 3'd1;
    cycle();
    checks++; if (bus.o_dw !== 8'd2 || bus.o_ready !== 1'b0) begin errors++; $display("FAIL full_ignore got dw=%0d r=%0b want dw=2 r=0", bus.o_dw, bus.o_ready); end
    bus.i_ready = 1'b1;
    cycle();
    $display("full drain dw=%0d", bus.o_dw);
    checks++; if (bus.o_dw !== 8'd4 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL full_second got dw=%0d v=%0b want dw=4 v=1", bus.o_dw, bus.o_valid); end
    cycle();
    $display("full drain dw=%0d", bus.o_dw);
    checks++; if (bus.o_dw !== 8'd1 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL full_third got dw=%0d v=%0b want dw=1 v=1", bus.o_dw, bus.o_valid); end
    bus.i_valid = 1'b0;
    cycle();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %0b want 0", bus.o_valid); end
    checks++; if (bus.o_err_cnt !== 8'd3) begin errors++; $display("FAIL full_cnt got %0d want 3", bus.o_err_cnt); end
  endtask

  task automatic test_reset_in_two();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_sel = 3'd2;
    cycle();
    bus.i_sel = 3'd3;
    cycle();
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL rst2_pre_ready got %0b want 0", bus.o_ready); end
    rst_n = 1'b0;
    cycle();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst2_valid got %0b want 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rst2_ready got %0b want 1", bus.o_ready); end
    checks++; if (bus.o_dw !== 8'd0) begin errors++; $display("FAIL rst2_dw got %0d want 0", bus.o_dw); end
    checks++; if (bus.o_err_cnt !== 8'd0) begin errors++; $display("FAIL rst2_cnt got %0d want 0", bus.o_err_cnt); end
    rst_n = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    cycle();
    cycle();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst2_ghost got %0b want 0", bus.o_valid); end
    $display("test_reset_in_two done");
  endtask

  task automatic test_saturation();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.i_sel = 3'(5 + $urandom_range(0, 2));
      bus.i_valid = 1'b1;
      cycle();
      checks++;
      if (bus.o_err_cnt !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
        errors++;
        $display("FAIL sat_cnt beat=%0d got %0d want %0d", i, bus.o_err_cnt, (i + 1 > 255) ? 255 : i + 1);
      end
    end
    bus.i_valid = 1'b0;
    cycle();
    $display("saturation cnt=%0d", bus.o_err_cnt);
  endtask

  task automatic test_random();
    logic [WIDTH:0]         q[$];
    logic [WIDTH:0]         beat;
    logic [N_SRC*WIDTH-1:0] src;
    logic [2:0]             s;
    logic                   v;
    logic                   r;
    int                     cnt;
    cnt = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      checks++; if (bus.o_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got %0b want %0b", n, bus.o_valid, q.size() > 0); end
      checks++; if (bus.o_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc=%0d got %0b want %0b", n, bus.o_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++;
        if ({bus.o_sel_err, bus.o_dw} !== q[0]) begin
          errors++;
          $display("FAIL rnd_beat cyc=%0d got %h want %h", n, {bus.o_sel_err, bus.o_dw}, q[0]);
        end
      end
      checks++; if (bus.o_err_cnt !== 8'(cnt)) begin errors++; $display("FAIL rnd_cnt cyc=%0d got %0d want %0d", n, bus.o_err_cnt, cnt); end
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      s = 3'($urandom_range(0, 7));
      src = {8'($urandom()), 32'($urandom())};
      bus.i_valid = v;
      bus.i_ready = r;
      bus.i_sel = s;
      bus.i_src = src;
      beat = ref_beat(s, src);
      if (v && q.size() < 2) begin
        if (r && q.size() > 0) void'(q.pop_front());
        q.push_back(beat);
        if (beat[WIDTH] && cnt < 255) cnt++;
      end else if (r && q.size() > 0) begin
        void'(q.pop_front());
      end
      cycle();
    end
    bus.i_valid = 1'b0;
    $display("test_random done, final occupancy %0d", q.size());
  endtask

  initial begin
    src_fixed = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    bus.i_sel = '0;
    bus.i_src = src_fixed;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_in_range();
    test_out_of_range();
    test_full();
    test_reset_in_two();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
